// File: rtl/comp_mult_pkg.sv
// comp_mult_pkg: shared widths, operand field offsets and result packing for
// the pipelined complex multiplier.
//   pwidth(dw) : width of one signed component product (2*dw)
//   rwidth(dw) : width of one result component (2*dw+2), sized so the
//                sum/difference of two products can never overflow
//   op_data  = {x1, y1, x2, y2}  (x1 in the most significant field)
//   res_data = {xr, yr}          (xr in the most significant field)
package comp_mult_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,  // op1 * op2
    MODE_CONJ   = 1'b1   // op1 * conj(op2)
  } conj_mode_e;

  function automatic int unsigned pwidth(input int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned rwidth(input int unsigned dw);
    return 2 * dw + 2;
  endfunction

  // Operand field LSB positions inside op_data.
  function automatic int unsigned x1_lsb(input int unsigned dw);
    return 3 * dw;
  endfunction

  function automatic int unsigned y1_lsb(input int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned x2_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned y2_lsb(input int unsigned dw);
    return 0 * dw;
  endfunction

  // Result field LSB positions inside res_data.
  function automatic int unsigned xr_lsb(input int unsigned rw);
    return rw;
  endfunction

  function automatic int unsigned yr_lsb(input int unsigned rw);
    return 0 * rw;
  endfunction

endpackage

// File: rtl/comp_mult_smul.sv
// comp_mult_smul: combinational signed DWIDTH x DWIDTH -> 2*DWIDTH multiplier.
// Ports:
//   a, b : signed operands, DWIDTH bits each
//   p    : signed full-precision product, 2*DWIDTH bits
module comp_mult_smul
  import comp_mult_pkg::*;
#(
  parameter int unsigned DWIDTH = 8
) (
  input  logic signed [DWIDTH-1:0]         a,
  input  logic signed [DWIDTH-1:0]         b,
  output logic signed [pwidth(DWIDTH)-1:0] p
);

  // Both operands are signed, so they are sign-extended to the product width
  // before multiplying; the product of two DWIDTH-bit values always fits.
  assign p = a * b;

endmodule

// File: rtl/comp_mult_pipe.sv
// comp_mult_pipe: three-stage pipelined signed complex multiplier with
// valid/ready handshakes on both sides and per-transaction conjugate mode.
//   S1: operand + conj register, S2: four registered products,
//   S3: add/subtract into the output register.
// All stages share one enable (en = ~res_val | res_rdy); op_rdy = en.
// Optional build macro COMP_MULT_PIPE_SAT_EN: clamp each result component to
// the signed OWIDTH range and flag it on res_sat (otherwise res_sat = 0).
// Ports:
//   clk, sw_rst        : clock, synchronous active-high reset
//   op_val/op_rdy      : operand handshake; op_conj, op_data = {x1,y1,x2,y2}
//   res_val/res_rdy    : result handshake; res_data = {xr,yr}, res_sat
module comp_mult_pipe
  import comp_mult_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned OWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          sw_rst,
  input  logic                          op_val,
  output logic                          op_rdy,
  input  logic                          op_conj,
  input  logic [4*DWIDTH-1:0]           op_data,
  output logic                          res_val,
  input  logic                          res_rdy,
  output logic [2*rwidth(DWIDTH)-1:0]   res_data,
  output logic                          res_sat
);

  localparam int unsigned PW = pwidth(DWIDTH);
  localparam int unsigned RW = rwidth(DWIDTH);

  localparam int unsigned X1_LSB = x1_lsb(DWIDTH);
  localparam int unsigned Y1_LSB = y1_lsb(DWIDTH);
  localparam int unsigned X2_LSB = x2_lsb(DWIDTH);
  localparam int unsigned Y2_LSB = y2_lsb(DWIDTH);
  localparam int unsigned XR_LSB = xr_lsb(RW);
  localparam int unsigned YR_LSB = yr_lsb(RW);

  if (OWIDTH < 2 || OWIDTH > 2 * DWIDTH + 1) begin : g_bad_owidth
    $error("comp_mult_pipe: OWIDTH out of range 2..2*DWIDTH+1");
  end

  logic en;

  // Stage 1
  logic                     v1;
  logic signed [DWIDTH-1:0] x1_q, y1_q, x2_q, y2_q;
  conj_mode_e               mode1;

  // Stage 2
  logic                     v2;
  logic signed [PW-1:0]     p1, p2, p3, p4;
  logic signed [PW-1:0]     p1_q, p2_q, p3_q, p4_q;
  conj_mode_e               mode2;

  // Stage 3 combinational result
  logic signed [RW-1:0]     e1, e2, e3, e4;
  logic signed [RW-1:0]     xr_full, yr_full;
  logic signed [RW-1:0]     xr_out, yr_out;
  logic                     sat_c;

  assign en     = ~res_val | res_rdy;
  assign op_rdy = en;

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      v1 <= 1'b0;
    end else if (en) begin
      v1    <= op_val;
      x1_q  <= op_data[X1_LSB +: DWIDTH];
      y1_q  <= op_data[Y1_LSB +: DWIDTH];
      x2_q  <= op_data[X2_LSB +: DWIDTH];
      y2_q  <= op_data[Y2_LSB +: DWIDTH];
      mode1 <= conj_mode_e'(op_conj);
    end
  end

  comp_mult_smul #(.DWIDTH(DWIDTH)) u_mul_p1 (.a(x1_q), .b(x2_q), .p(p1));
  comp_mult_smul #(.DWIDTH(DWIDTH)) u_mul_p2 (.a(x1_q), .b(y2_q), .p(p2));
  comp_mult_smul #(.DWIDTH(DWIDTH)) u_mul_p3 (.a(x2_q), .b(y1_q), .p(p3));
  comp_mult_smul #(.DWIDTH(DWIDTH)) u_mul_p4 (.a(y1_q), .b(y2_q), .p(p4));

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      v2 <= 1'b0;
    end else if (en) begin
      v2    <= v1;
      p1_q  <= p1;
      p2_q  <= p2;
      p3_q  <= p3;
      p4_q  <= p4;
      mode2 <= mode1;
    end
  end

  always_comb begin
    e1 = {{(RW-PW){p1_q[PW-1]}}, p1_q};
    e2 = {{(RW-PW){p2_q[PW-1]}}, p2_q};
    e3 = {{(RW-PW){p3_q[PW-1]}}, p3_q};
    e4 = {{(RW-PW){p4_q[PW-1]}}, p4_q};
    if (mode2 == MODE_CONJ) begin
      xr_full = e1 + e4;
      yr_full = e3 - e2;
    end else begin
      xr_full = e1 - e4;
      yr_full = e2 + e3;
    end
  end

`ifdef COMP_MULT_PIPE_SAT_EN
  localparam logic signed [RW-1:0] SAT_MAX =
    {{(RW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN =
    {{(RW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

  always_comb begin
    xr_out = xr_full;
    yr_out = yr_full;
    sat_c  = 1'b0;
    if (xr_full > SAT_MAX) begin
      xr_out = SAT_MAX;
      sat_c  = 1'b1;
    end else if (xr_full < SAT_MIN) begin
      xr_out = SAT_MIN;
      sat_c  = 1'b1;
    end
    if (yr_full > SAT_MAX) begin
      yr_out = SAT_MAX;
      sat_c  = 1'b1;
    end else if (yr_full < SAT_MIN) begin
      yr_out = SAT_MIN;
      sat_c  = 1'b1;
    end
  end
`else
  always_comb begin
    xr_out = xr_full;
    yr_out = yr_full;
    sat_c  = 1'b0;
  end
`endif

  // The output register only loads on a real result so that a bubble entering
  // S3 does not disturb the last value on res_data.
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      res_val  <= 1'b0;
      res_data <= '0;
      res_sat  <= 1'b0;
    end else if (en) begin
      res_val <= v2;
      if (v2) begin
        res_data[XR_LSB +: RW] <= xr_out;
        res_data[YR_LSB +: RW] <= yr_out;
        res_sat                <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_comp_mult_pipe.sv
// tb_comp_mult_pipe: self-checking bench for comp_mult_pipe (DWIDTH=8,
// OWIDTH=16). A queue-based reference model computes each expected result from
// the complex-multiply rules; a negedge monitor checks every transfer, the
// op_rdy rule, output stability under backpressure and reset behaviour.
// Directed sequences pin latency and hand-computed values; a random phase
// toggles op_val/res_rdy over 10k operations.
module tb_comp_mult_pipe;

  localparam int DW = 8;
  localparam int OW = 16;
  localparam int RW = 18;

  logic          clk = 1'b0;
  logic          sw_rst = 1'b1;
  logic          op_val = 1'b0;
  logic          op_rdy;
  logic          op_conj = 1'b0;
  logic [31:0]   op_data = '0;
  logic          res_val;
  logic          res_rdy = 1'b1;
  logic [35:0]   res_data;
  logic          res_sat;

  always #5 clk = ~clk;

  comp_mult_pipe #(.DWIDTH(DW), .OWIDTH(OW)) dut (
    .clk      (clk),
    .sw_rst   (sw_rst),
    .op_val   (op_val),
    .op_rdy   (op_rdy),
    .op_conj  (op_conj),
    .op_data  (op_data),
    .res_val  (res_val),
    .res_rdy  (res_rdy),
    .res_data (res_data),
    .res_sat  (res_sat)
  );

  typedef struct {
    logic [35:0] data;
    logic        sat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic c);
    logic signed [31:0] x1, y1, x2, y2, xr, yr, hi, lo;
    exp_t e;
    x1 = 32'($signed(d[31:24]));
    y1 = 32'($signed(d[23:16]));
    x2 = 32'($signed(d[15:8]));
    y2 = 32'($signed(d[7:0]));
    // (x1 + j y1)(x2 +/- j y2)
    if (c) begin
      xr = x1 * x2 + y1 * y2;
      yr = y1 * x2 - x1 * y2;
    end else begin
      xr = x1 * x2 - y1 * y2;
      yr = x1 * y2 + y1 * x2;
    end
    e.sat = 1'b0;
    hi = (32'sd1 <<< (OW - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (OW - 1));
`ifdef COMP_MULT_PIPE_SAT_EN
    if (xr > hi) begin xr = hi; e.sat = 1'b1; end
    if (xr < lo) begin xr = lo; e.sat = 1'b1; end
    if (yr > hi) begin yr = hi; e.sat = 1'b1; end
    if (yr < lo) begin yr = lo; e.sat = 1'b1; end
`else
    if (hi < lo) e.sat = 1'b1;
`endif
    e.data = {xr[RW-1:0], yr[RW-1:0]};
    return e;
  endfunction

  // Monitor / scoreboard, sampling away from the active edge.
  logic        hold_prev = 1'b0;
  logic        rst_prev = 1'b0;
  logic [35:0] data_prev = '0;
  logic        sat_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (sw_rst) begin
      q.delete();
      hold_prev = 1'b0;
      rst_prev  = 1'b1;
    end else begin
      if (rst_prev) begin
        chk("after_reset_res_val", res_val, 0);
        chk("after_reset_res_data", res_data, 0);
        chk("after_reset_res_sat", res_sat, 0);
      end
      chk("op_rdy_rule", op_rdy, !res_val || res_rdy);
      if (hold_prev) begin
        chk("stall_res_val_held", res_val, 1);
        chk("stall_res_data_stable", res_data, data_prev);
        chk("stall_res_sat_stable", res_sat, sat_prev);
      end
      if (res_val && res_rdy) begin
        chk("result_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_sat", res_sat, e.sat);
        end
      end
      if (op_val && op_rdy) begin
        q.push_back(model(op_data, op_conj));
        n_acc++;
      end
      hold_prev = res_val && !res_rdy;
      data_prev = res_data;
      sat_prev  = res_sat;
      rst_prev  = 1'b0;
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic c);
    op_val  = v;
    op_data = d;
    op_conj = c;
  endtask

  function automatic logic [7:0] rnd_byte();
    int unsigned r;
    r = $urandom_range(3);
    if (r == 0) return 8'h80;
    if (r == 1) return 8'h7f;
    return 8'($urandom);
  endfunction

  initial begin
    exp_t m;
    logic [31:0] d_small;
    logic [31:0] d_min;
    int   k;
    int   start_acc;
    int   cyc;
    d_small = {8'sd3, 8'sd4, 8'sd1, 8'sd2};
    d_min   = {4{8'h80}};

    // Hand-computed pins on the reference model.
    m = model(d_small, 1'b0);
    chk("model_pin_direct", m.data, {18'h3fffb, 18'h0000a});
    m = model(d_small, 1'b1);
    chk("model_pin_conj", m.data, {18'h0000b, 18'h3fffe});
    m = model(d_min, 1'b0);
`ifdef COMP_MULT_PIPE_SAT_EN
    chk("model_pin_min", m.data, {18'h00000, 18'h07fff});
    chk("model_pin_min_sat", m.sat, 1);
`else
    chk("model_pin_min", m.data, {18'h00000, 18'h08000});
    chk("model_pin_min_sat", m.sat, 0);
`endif

    repeat (2) @(posedge clk);
    #1 sw_rst = 1'b0;
    @(negedge clk);
    chk("reset_op_rdy", op_rdy, 1);
    chk("reset_res_val", res_val, 0);

    // Tests 1/2: back-to-back direct then conjugate, latency 3 cycles.
    @(posedge clk); #1 drive(1'b1, d_small, 1'b0);
    @(posedge clk); #1 drive(1'b1, d_small, 1'b1);
    @(posedge clk); #1 drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("lat_not_early", res_val, 0);
    @(negedge clk);
    chk("t1_res_val", res_val, 1);
    chk("t1_res_data", res_data, {18'h3fffb, 18'h0000a});
    @(negedge clk);
    chk("t2_res_val", res_val, 1);
    chk("t2_res_data", res_data, {18'h0000b, 18'h3fffe});
    @(negedge clk);
    chk("t2_then_idle", res_val, 0);

    // Test 3: most negative operands, no wrap (or clamp in saturating build).
    @(posedge clk); #1 drive(1'b1, d_min, 1'b0);
    @(posedge clk); #1 drive(1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t3_res_val", res_val, 1);
`ifdef COMP_MULT_PIPE_SAT_EN
    chk("t3_res_data", res_data, {18'h00000, 18'h07fff});
    chk("t3_res_sat", res_sat, 1);
`else
    chk("t3_res_data", res_data, {18'h00000, 18'h08000});
    chk("t3_res_sat", res_sat, 0);
`endif

    // Test 4: stream 5, then stall 4 cycles, then drain.
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 drive(1'b1, $urandom, 1'($urandom_range(1)));
    end
    @(posedge clk); #1 res_rdy = 1'b0;
    drive(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_stall_op_rdy", op_rdy, 0);
      @(posedge clk); #1 drive(1'b1, $urandom, 1'($urandom_range(1)));
    end
    res_rdy = 1'b1;
    drive(1'b0, '0, 1'b0);
    k = q.size();
    chk("t4_pending_after_stall", k, 3);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("t4_drain_val", res_val, 1);
    end
    @(negedge clk);
    chk("t4_drained", res_val, 0);
    chk("t4_queue_empty", q.size(), 0);

    // Test 5: reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 drive(1'b1, $urandom, 1'($urandom_range(1)));
    end
    @(posedge clk); #1 drive(1'b0, '0, 1'b0);
    sw_rst  = 1'b1;
    res_rdy = 1'b0;
    @(posedge clk); #1 sw_rst = 1'b0;
    res_rdy = 1'b1;
    @(negedge clk);
    chk("t5_res_val", res_val, 0);
    chk("t5_res_data", res_data, 0);
    chk("t5_op_rdy", op_rdy, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_stale", res_val, 0);
    end

    // Test 6: random traffic over 10k operations.
    start_acc = n_acc;
    cyc = 0;
    while ((n_acc - start_acc) < 10000 && cyc < 40000) begin
      @(posedge clk); #1;
      op_val  = ($urandom_range(3) != 0);
      op_data = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
      op_conj = 1'($urandom_range(1));
      res_rdy = ($urandom_range(3) != 0);
      cyc++;
    end
    chk("t6_ops_completed", (n_acc - start_acc) >= 10000, 1);
    @(posedge clk); #1 drive(1'b0, '0, 1'b0);
    res_rdy = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || res_val) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_queue_empty", q.size(), 0);
    chk("t6_res_val_idle", res_val, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete, got %0d checks, expected completion", n_chk);
    $fatal(1);
  end

endmodule
